axi_lite_master_p: RTL and testbench

Parametrised AXI4-Lite master that turns a simple single-outstanding command interface into full AXI4-Lite write and read transactions.
- Adds configurable address and data width, byte strobes, and independent AW/W handshake completion.
- Latches the request so the command bus need not be held stable during the transaction.
- Adds a response capture path with BRESP/RRESP and a saturating error counter.
- Sits between a local controller (CPU-side FSM, UART bridge) and the AXI-Lite interconnect.

---
 rtl/axi_lite_master_p.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_axi_lite_master_p.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_p.sv
// axi_lite_master_p
// -----------------------------------------------------------------------------
// Single-outstanding AXI4-Lite master. A local controller hands over one
// command (read or write) on the cmd_* bus; the master latches it, runs the
// matching AXI4-Lite transaction and reports the outcome on the rsp_* bus with
// a one-cycle rsp_valid pulse. Non-OKAY responses are counted in a saturating
// error counter that can be cleared synchronously.
//
// Ports
//   ACLK, ARESETn             clock (rising edge) and asynchronous active-low reset
//   AW* / W* / B*             AXI4-Lite write address, write data, write response
//   AR* / R*                  AXI4-Lite read address, read data
//   cmd_valid / cmd_ready     command handshake (cmd_ready = master idle)
//   cmd_write                 1 = write, 0 = read
//   cmd_addr/wdata/wstrb      command payload, sampled on acceptance only
//   rsp_valid                 one-cycle completion pulse
//   rsp_write/resp/rdata      outcome of the last transaction, held until the next
//   err_count / err_clr       saturating count of non-OKAY responses, sync clear
//
// Every AXI and rsp output is driven straight from a flop, so no AXI input
// reaches an AXI output through combinational logic.
// -----------------------------------------------------------------------------
module axi_lite_master_p #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,  // 32 or 64
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  // write address channel
  output logic [ADDR_WIDTH-1:0]      AWADDR,
  output logic [2:0]                 AWPROT,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  // write data channel
  output logic [DATA_WIDTH-1:0]      WDATA,
  output logic [DATA_WIDTH/8-1:0]    WSTRB,
  output logic                       WVALID,
  input  logic                       WREADY,
  // write response channel
  input  logic [1:0]                 BRESP,
  input  logic                       BVALID,
  output logic                       BREADY,
  // read address channel
  output logic [ADDR_WIDTH-1:0]      ARADDR,
  output logic [2:0]                 ARPROT,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  // read data channel
  input  logic [DATA_WIDTH-1:0]      RDATA,
  input  logic [1:0]                 RRESP,
  input  logic                       RVALID,
  output logic                       RREADY,
  // command interface
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]    cmd_wstrb,
  // response interface
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic [1:0]                 rsp_resp,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  // error counter
  output logic [ERR_CNT_WIDTH-1:0]   err_count,
  input  logic                       err_clr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // channel valid/ready flops and their next values
  logic awvalid_reg, awvalid_next;
  logic wvalid_reg,  wvalid_next;
  logic bready_reg,  bready_next;
  logic arvalid_reg, arvalid_next;
  logic rready_reg,  rready_next;
  logic rsp_valid_reg, rsp_valid_next;

  // latched command payload (these flops are the AXI address/data outputs)
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [ADDR_WIDTH-1:0] araddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] wstrb_reg;

  // captured response
  logic                  rsp_write_reg;
  logic [1:0]            rsp_resp_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg;

  // single-cycle strobes from the FSM
  logic accept;
  logic capture_b;
  logic capture_r;
  logic aw_done;
  logic w_done;
  logic resp_err;

  // ---------------------------------------------------------------------------
  // State register and registered channel controls
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg     <= IDLE;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = 1'b0;
    accept         = 1'b0;
    capture_b      = 1'b0;
    capture_r      = 1'b0;
    aw_done        = 1'b0;
    w_done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_write) begin
            state_next   = WR_AW_W;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = RD_AR;
            arvalid_next = 1'b1;
          end
        end
      end

      WR_AW_W: begin
        // A channel whose VALID has already dropped has completed its
        // handshake, so the VALID flop doubles as the per-channel done flag.
        aw_done = !awvalid_reg || AWREADY;
        w_done  = !wvalid_reg  || WREADY;
        if (awvalid_reg && AWREADY) awvalid_next = 1'b0;
        if (wvalid_reg  && WREADY)  wvalid_next  = 1'b0;
        if (aw_done && w_done) begin
          state_next  = WR_B;
          bready_next = 1'b1;
        end
      end

      WR_B: begin
        if (BVALID) begin
          capture_b      = 1'b1;
          bready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end

      RD_AR: begin
        if (ARREADY) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_R;
        end
      end

      RD_R: begin
        if (RVALID) begin
          capture_r      = 1'b1;
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next   = IDLE;
        awvalid_next = 1'b0;
        wvalid_next  = 1'b0;
        bready_next  = 1'b0;
        arvalid_next = 1'b0;
        rready_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch and response capture
  // ---------------------------------------------------------------------------
  // Address/data only load on acceptance, so they stay stable while VALID is
  // high no matter what the command bus does afterwards.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rsp_write_reg <= 1'b0;
      rsp_resp_reg  <= 2'b00;
      rsp_rdata_reg <= '0;
    end else begin
      if (accept && cmd_write) begin
        awaddr_reg <= cmd_addr;
        wdata_reg  <= cmd_wdata;
        wstrb_reg  <= cmd_wstrb;
      end
      if (accept && !cmd_write) begin
        araddr_reg <= cmd_addr;
      end
      if (capture_b) begin
        rsp_write_reg <= 1'b1;
        rsp_resp_reg  <= BRESP;
        rsp_rdata_reg <= '0;
      end
      if (capture_r) begin
        rsp_write_reg <= 1'b0;
        rsp_resp_reg  <= RRESP;
        rsp_rdata_reg <= RDATA;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating error counter; a clear wins over a same-cycle error
  // ---------------------------------------------------------------------------
  assign resp_err = (capture_b && (BRESP != 2'b00)) ||
                    (capture_r && (RRESP != 2'b00));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_count_reg <= '0;
    end else if (err_clr) begin
      err_count_reg <= '0;
    end else if (resp_err && (err_count_reg != {ERR_CNT_WIDTH{1'b1}})) begin
      err_count_reg <= err_count_reg + ERR_CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output assignments
  // ---------------------------------------------------------------------------
  assign AWADDR    = awaddr_reg;
  assign AWPROT    = 3'b000;
  assign AWVALID   = awvalid_reg;
  assign WDATA     = wdata_reg;
  assign WSTRB     = wstrb_reg;
  assign WVALID    = wvalid_reg;
  assign BREADY    = bready_reg;
  assign ARADDR    = araddr_reg;
  assign ARPROT    = 3'b000;
  assign ARVALID   = arvalid_reg;
  assign RREADY    = rready_reg;

  assign cmd_ready = (state_reg == IDLE);

  assign rsp_valid = rsp_valid_reg;
  assign rsp_write = rsp_write_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_axi_lite_master_p.sv
// tb_axi_lite_master_p
// -----------------------------------------------------------------------------
// Self-checking bench for axi_lite_master_p (ERR_CNT_WIDTH = 2 so saturation
// is reachable quickly). A bench-side AXI-Lite slave with per-channel delays
// answers the master. A transaction-level model tracks which channel
// handshakes a command still owes and what the response bus must show, and
// is compared with the DUT on every falling clock edge. Directed sequences pin
// the model with hand-computed literals; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_p;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = 2;
  localparam int ERR_MAX = 3;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [AW-1:0] AWADDR;  logic [2:0] AWPROT;  logic AWVALID;  logic AWREADY = 1'b0;
  logic [DW-1:0] WDATA;   logic [SW-1:0] WSTRB; logic WVALID;  logic WREADY  = 1'b0;
  logic [1:0] BRESP = 2'b00; logic BVALID = 1'b0; logic BREADY;
  logic [AW-1:0] ARADDR;  logic [2:0] ARPROT;  logic ARVALID;  logic ARREADY = 1'b0;
  logic [DW-1:0] RDATA = '0; logic [1:0] RRESP = 2'b00; logic RVALID = 1'b0; logic RREADY;
  logic cmd_valid = 1'b0; logic cmd_ready; logic cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0; logic [DW-1:0] cmd_wdata = '0; logic [SW-1:0] cmd_wstrb = '0;
  logic rsp_valid; logic rsp_write; logic [1:0] rsp_resp; logic [DW-1:0] rsp_rdata;
  logic [EW-1:0] err_count; logic err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_master_p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_resp(rsp_resp),
    .rsp_rdata(rsp_rdata), .err_count(err_count), .err_clr(err_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bench slave: knobs and state (written only by the stimulus process)
  // ---------------------------------------------------------------------------
  bit rand_mode = 1'b0;
  bit clr_on_resp = 1'b0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] b_resp_fix = 2'b00, r_resp_fix = 2'b00;
  logic [DW-1:0] r_data_fix = '0;
  int s_aw_cnt = 0, s_w_cnt = 0, s_ar_cnt = 0, s_b_cnt = 0, s_r_cnt = 0;
  bit s_aw_got = 0, s_w_got = 0, s_b_pend = 0, s_r_pend = 0;
  bit h_aw = 0, h_w = 0, h_ar = 0, h_b = 0, h_r = 0;

  function automatic logic [1:0] pick_resp();
    return ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endfunction

  // Called 2 time units after each rising edge; h_* hold the handshakes that
  // completed on that edge.
  task automatic drive_slave();
    if (!ARESETn) begin
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      s_aw_cnt = 0; s_w_cnt = 0; s_ar_cnt = 0; s_b_cnt = 0; s_r_cnt = 0;
      s_aw_got = 0; s_w_got = 0; s_b_pend = 0; s_r_pend = 0;
      h_aw = 0; h_w = 0; h_ar = 0; h_b = 0; h_r = 0;
      return;
    end
    if (h_aw) s_aw_got = 1;
    if (h_w)  s_w_got  = 1;
    if (h_b) begin s_b_pend = 0; s_aw_got = 0; s_w_got = 0; BVALID = 0; end
    if (h_r) begin s_r_pend = 0; RVALID = 0; end
    if (h_ar) begin
      s_r_pend = 1; s_r_cnt = 0;
      if (rand_mode) begin r_dly = $urandom_range(0, 4); RRESP = pick_resp(); RDATA = $urandom; end
      else begin RRESP = r_resp_fix; RDATA = r_data_fix; end
    end
    if (s_aw_got && s_w_got && !s_b_pend) begin
      s_b_pend = 1; s_b_cnt = 0;
      if (rand_mode) begin b_dly = $urandom_range(0, 4); BRESP = pick_resp(); end
      else BRESP = b_resp_fix;
    end
    if (s_b_pend) begin BVALID = (s_b_cnt >= b_dly); s_b_cnt++; end
    if (s_r_pend) begin RVALID = (s_r_cnt >= r_dly); s_r_cnt++; end
    if (AWVALID) begin AWREADY = (s_aw_cnt >= aw_dly); s_aw_cnt++; end
    else begin AWREADY = 0; s_aw_cnt = 0; if (rand_mode) aw_dly = $urandom_range(0, 3); end
    if (WVALID) begin WREADY = (s_w_cnt >= w_dly); s_w_cnt++; end
    else begin WREADY = 0; s_w_cnt = 0; if (rand_mode) w_dly = $urandom_range(0, 3); end
    if (ARVALID) begin ARREADY = (s_ar_cnt >= ar_dly); s_ar_cnt++; end
    else begin ARREADY = 0; s_ar_cnt = 0; if (rand_mode) ar_dly = $urandom_range(0, 3); end
    if (rand_mode) err_clr = ($urandom_range(0, 24) == 0);
    else err_clr = clr_on_resp && RVALID && RREADY;
    h_aw = AWVALID && AWREADY; h_w = WVALID && WREADY; h_ar = ARVALID && ARREADY;
    h_b = BVALID && BREADY;    h_r = RVALID && RREADY;
  endtask

  task automatic tick();
    @(posedge ACLK); #2;
    drive_slave();
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    chk("cmd_ready_at_issue", cmd_ready, 1);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    do begin tick(); n++; end while (!rsp_valid && n < max);
    chk("rsp_valid_within_bound", rsp_valid, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model and per-cycle compare
  // ---------------------------------------------------------------------------
  bit m_act = 0, m_wr = 0, m_awd = 0, m_wd = 0, m_ard = 0;
  logic [AW-1:0] m_addr = '0; logic [DW-1:0] m_wdata = '0; logic [SW-1:0] m_wstrb = '0;
  logic m_rsp_write = 0; logic [1:0] m_rsp_resp = 0; logic [DW-1:0] m_rsp_rdata = '0;
  int m_err = 0;
  int n_rsp = 0;
  bit p_acc = 0, p_aw = 0, p_w = 0, p_ar = 0, p_b = 0, p_r = 0, p_clr = 0;
  logic p_cwr = 0; logic [AW-1:0] p_caddr = '0; logic [DW-1:0] p_cdata = '0;
  logic [SW-1:0] p_cstrb = '0; logic [1:0] p_bresp = 0, p_rresp = 0; logic [DW-1:0] p_rdata = '0;

  always @(negedge ACLK) begin : compare
    bit e_awv, e_wv, e_br, e_arv, e_rr, e_rspv;
    if (!ARESETn) begin
      m_act = 0; m_rsp_write = 0; m_rsp_resp = 0; m_rsp_rdata = '0; m_err = 0;
      p_acc = 0; p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0; p_clr = 0;
      chk("rst_AWVALID", AWVALID, 0); chk("rst_WVALID", WVALID, 0);
      chk("rst_BREADY", BREADY, 0);   chk("rst_ARVALID", ARVALID, 0);
      chk("rst_RREADY", RREADY, 0);   chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_AWADDR", AWADDR, 0);   chk("rst_ARADDR", ARADDR, 0);
      chk("rst_WDATA", WDATA, 0);     chk("rst_WSTRB", WSTRB, 0);
      chk("rst_rsp_write", rsp_write, 0); chk("rst_rsp_resp", rsp_resp, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0); chk("rst_err_count", err_count, 0);
    end else begin
      e_rspv = 0;
      if (p_acc) begin
        m_act = 1; m_wr = p_cwr; m_addr = p_caddr; m_wdata = p_cdata; m_wstrb = p_cstrb;
        m_awd = 0; m_wd = 0; m_ard = 0;
      end
      if (p_aw) m_awd = 1;
      if (p_w)  m_wd  = 1;
      if (p_ar) m_ard = 1;
      if (p_b) begin
        m_act = 0; e_rspv = 1; m_rsp_write = 1; m_rsp_resp = p_bresp; m_rsp_rdata = '0;
        if (p_bresp != 0 && m_err < ERR_MAX) m_err++;
      end
      if (p_r) begin
        m_act = 0; e_rspv = 1; m_rsp_write = 0; m_rsp_resp = p_rresp; m_rsp_rdata = p_rdata;
        if (p_rresp != 0 && m_err < ERR_MAX) m_err++;
      end
      if (p_clr) m_err = 0;
      if (e_rspv) n_rsp++;

      // A channel is presented from the cycle after acceptance until the cycle
      // of its own handshake; the response side opens once all requests are done.
      e_awv = m_act && m_wr && !m_awd;
      e_wv  = m_act && m_wr && !m_wd;
      e_br  = m_act && m_wr && m_awd && m_wd;
      e_arv = m_act && !m_wr && !m_ard;
      e_rr  = m_act && !m_wr && m_ard;

      chk("AWVALID", AWVALID, e_awv); chk("WVALID", WVALID, e_wv);
      chk("BREADY", BREADY, e_br);    chk("ARVALID", ARVALID, e_arv);
      chk("RREADY", RREADY, e_rr);    chk("cmd_ready", cmd_ready, !m_act);
      chk("AWPROT", AWPROT, 0);       chk("ARPROT", ARPROT, 0);
      if (e_awv) chk("AWADDR", AWADDR, m_addr);
      if (e_wv) begin chk("WDATA", WDATA, m_wdata); chk("WSTRB", WSTRB, m_wstrb); end
      if (e_arv) chk("ARADDR", ARADDR, m_addr);
      chk("rsp_valid", rsp_valid, e_rspv);
      chk("rsp_write", rsp_write, m_rsp_write);
      chk("rsp_resp", rsp_resp, m_rsp_resp);
      chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
      chk("err_count", err_count, m_err);

      p_acc = cmd_valid && !m_act;
      p_cwr = cmd_write; p_caddr = cmd_addr; p_cdata = cmd_wdata; p_cstrb = cmd_wstrb;
      p_aw = e_awv && AWREADY; p_w = e_wv && WREADY; p_ar = e_arv && ARREADY;
      p_b = e_br && BVALID;    p_r = e_rr && RVALID;
      p_bresp = BRESP; p_rresp = RRESP; p_rdata = RDATA; p_clr = err_clr;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int exp_err[4];
    exp_err = '{1, 2, 3, 3};

    // reset state
    repeat (3) tick();
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_AWVALID", AWVALID, 0);
    ARESETn = 1;
    tick();

    // 1: write, always-ready slave answering one cycle after the handshake
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF);                       // cycle N+1
    chk("t1_AWVALID_n1", AWVALID, 1); chk("t1_WVALID_n1", WVALID, 1);
    chk("t1_AWADDR", AWADDR, 32'h10); chk("t1_WDATA", WDATA, 32'hDEADBEEF);
    chk("t1_WSTRB", WSTRB, 4'hF);
    tick();                                                      // N+2
    chk("t1_AWVALID_n2", AWVALID, 0); chk("t1_WVALID_n2", WVALID, 0);
    chk("t1_BREADY_n2", BREADY, 1);   chk("t1_rsp_valid_n2", rsp_valid, 0);
    tick();                                                      // N+3
    chk("t1_rsp_valid_n3", rsp_valid, 1); chk("t1_rsp_write", rsp_write, 1);
    chk("t1_rsp_resp", rsp_resp, 0);      chk("t1_rsp_rdata", rsp_rdata, 0);
    chk("t1_err_count", err_count, 0);    chk("t1_cmd_ready", cmd_ready, 1);
    tick();
    chk("t1_rsp_valid_pulse", rsp_valid, 0); chk("t1_rsp_write_hold", rsp_write, 1);

    // 2: AWREADY three cycles late, WREADY immediate
    aw_dly = 3;
    issue(1, 32'h20, 32'hA5A5_0F0F, 4'h3);                       // N+1
    cmd_addr = 32'hFFFF_0000;
    chk("t2_AWVALID_n1", AWVALID, 1); chk("t2_WVALID_n1", WVALID, 1);
    for (int i = 0; i < 3; i++) begin                            // N+2..N+4
      tick();
      chk("t2_WVALID_low", WVALID, 0); chk("t2_AWVALID_held", AWVALID, 1);
      chk("t2_AWADDR_stable", AWADDR, 32'h20); chk("t2_BREADY_wait", BREADY, 0);
    end
    tick();                                                      // N+5
    chk("t2_AWVALID_drop", AWVALID, 0); chk("t2_BREADY_rise", BREADY, 1);
    tick();                                                      // N+6
    chk("t2_rsp_valid", rsp_valid, 1);
    aw_dly = 0;

    // 3: read with RVALID five cycles late
    r_dly = 5; r_data_fix = 32'h12345678;
    issue(0, 32'h4, 32'h0, 4'h0);                                // N+1
    chk("t3_ARVALID", ARVALID, 1); chk("t3_ARADDR", ARADDR, 32'h4);
    for (int i = 0; i < 6; i++) begin                            // N+2..N+7
      tick();
      chk("t3_RREADY_held", RREADY, 1); chk("t3_no_rsp_yet", rsp_valid, 0);
    end
    tick();                                                      // N+8
    chk("t3_rsp_valid", rsp_valid, 1); chk("t3_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("t3_rsp_write", rsp_write, 0); chk("t3_rsp_resp", rsp_resp, 0);
    r_dly = 0;

    // 4: saturating error counter, then clear coincident with an error
    err_clr = 1; tick();
    chk("t4_cleared", err_count, 0);
    r_resp_fix = 2'b10;
    for (int i = 0; i < 4; i++) begin
      issue(0, 32'h40 + 32'(4 * i), 32'h0, 4'h0);
      wait_rsp(20, n);
      chk("t4_rsp_resp", rsp_resp, 2'b10);
      chk("t4_err_count", err_count, exp_err[i]);
    end
    clr_on_resp = 1;
    issue(0, 32'h80, 32'h0, 4'h0);
    wait_rsp(20, n);
    chk("t4_clr_priority", err_count, 0);
    clr_on_resp = 0; r_resp_fix = 2'b00;

    // 5: back-to-back write then read with cmd_valid held high
    aw_dly = 2;
    issue(1, 32'h100, 32'h0BAD_F00D, 4'hC);                      // N+1
    chk("t5_AWADDR_n1", AWADDR, 32'h100);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h200;
    tick();                                                      // N+2
    chk("t5_AWVALID_n2", AWVALID, 1); chk("t5_AWADDR_n2", AWADDR, 32'h100);
    wait_rsp(20, n);
    chk("t5_wr_rsp", rsp_write, 1); chk("t5_cmd_ready_in_rsp", cmd_ready, 1);
    tick();
    chk("t5_ARVALID", ARVALID, 1); chk("t5_ARADDR", ARADDR, 32'h200);
    chk("t5_cmd_ready_busy", cmd_ready, 0);
    cmd_valid = 0;
    wait_rsp(20, n);
    chk("t5_rd_rsp", rsp_write, 0);
    aw_dly = 0;

    // 6: reset while AWVALID waits for AWREADY
    aw_dly = 20;
    issue(1, 32'h30, 32'h1111_2222, 4'hF);
    tick();
    chk("t6_AWVALID_waiting", AWVALID, 1);
    ARESETn = 0; #1;
    chk("t6_AWVALID_reset", AWVALID, 0); chk("t6_WVALID_reset", WVALID, 0);
    chk("t6_cmd_ready_reset", cmd_ready, 1);
    tick(); tick();
    ARESETn = 1;
    aw_dly = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_rsp", rsp_valid, 0); chk("t6_cmd_ready", cmd_ready, 1);
    end

    // randomized traffic, slave delays/responses, clears and occasional resets
    rand_mode = 1;
    for (int c = 0; c < 2500; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        cmd_valid = 0; ARESETn = 0; #1;
        chk("rnd_AWVALID_reset", AWVALID, 0); chk("rnd_ARVALID_reset", ARVALID, 0);
        chk("rnd_rsp_valid_reset", rsp_valid, 0);
        tick();
        ARESETn = 1;
      end else begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom & 32'hFFFF_FFFC;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom_range(0, 15));
      end
    end
    cmd_valid = 0; rand_mode = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    repeat (30) tick();
    chk("rnd_rsp_count_min", n_rsp >= 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
